// File: rtl/sub_result_fifo_if.sv
// Handshake/data bundle between the subtractor host side and the result FIFO.
// The master drives strobes and data; the slave (the FIFO) returns status and head data.
interface sub_result_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             ena;
  logic [WIDTH-1:0] diff_in;
  logic             borrow_in;
  logic             push_req;
  logic             pop_req;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic             borrow_out;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output ena, diff_in, borrow_in, push_req, pop_req, clr,
    input  dout, borrow_out, empty, full, count, overflow, underflow
  );

  modport slave (
    input  ena, diff_in, borrow_in, push_req, pop_req, clr,
    output dout, borrow_out, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/sub_result_fifo.sv
// Capture FIFO for subtractor results {borrow, diff}; push/pop on rising edges of
// slow level strobes, with sticky overflow/underflow flags and synchronous clear.
module sub_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sub_result_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic             push_q, pop_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic             wr_en;
  logic             push_ev, pop_ev, do_push, do_pop;
  logic [WIDTH:0]   head;

  assign push_ev = bus.push_req & ~push_q & bus.ena;
  assign pop_ev  = bus.pop_req  & ~pop_q  & bus.ena;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    if (bus.ena && bus.clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // A full FIFO still accepts a push when a pop frees the head in the same cycle.
      do_push = push_ev && ((count_q != FULL_CNT) || pop_ev);
      do_pop  = pop_ev && (count_q != '0);
      if (push_ev && !do_push) overflow_d  = 1'b1;
      if (pop_ev && !do_pop)   underflow_d = 1'b1;
      if (do_push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      push_q      <= bus.push_req;
      pop_q       <= bus.pop_req;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {bus.borrow_in, bus.diff_in};
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.dout       = (count_q != '0) ? head[WIDTH-1:0] : '0;
  assign bus.borrow_out = (count_q != '0) ? head[WIDTH] : 1'b0;
  assign bus.empty      = (count_q == '0);
  assign bus.full       = (count_q == FULL_CNT);
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_sub_result_fifo.sv
// Directed bench for sub_result_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for held strobes, full push+pop, wrap and async reset.
module tb_sub_result_fifo;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  sub_result_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  sub_result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] diff;
    logic       bor;
    int         e_count;
    logic [7:0] e_dout;
    logic       e_bor;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic e, logic pu, logic po, logic c, logic [7:0] d, logic b,
                              int ec, logic [7:0] ed, logic eb, logic eo, logic eu);
    vec_t v;
    v.ena = e; v.push = pu; v.pop = po; v.clr = c; v.diff = d; v.bor = b;
    v.e_count = ec; v.e_dout = ed; v.e_bor = eb; v.e_ovf = eo; v.e_udf = eu;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Drive inputs just after a falling edge, let one rising edge commit, sample at the next falling edge.
  task automatic step(logic e, logic pu, logic po, logic c, logic [7:0] d, logic b);
    bus.ena = e; bus.push_req = pu; bus.pop_req = po; bus.clr = c;
    bus.diff_in = d; bus.borrow_in = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(string tag, int ec, logic [7:0] ed, logic eb, logic eo, logic eu);
    chk({tag, ".count"}, int'(bus.count), ec);
    chk({tag, ".dout"}, int'({bus.borrow_out, bus.dout}), int'({eb, ed}));
    chk({tag, ".flags"}, int'({bus.empty, bus.full, bus.overflow, bus.underflow}),
        int'({ec == 0, ec == 4, eo, eu}));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.ena = 1'b0; bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.clr = 1'b0;
    bus.diff_in = '0; bus.borrow_in = 1'b0;

    // ena push pop clr diff bor | count dout bor ovf udf
    add(1,0,0,0,8'h00,0, 0,8'h00,0,0,0);
    add(1,1,0,0,8'h05,0, 1,8'h05,0,0,0);
    add(1,0,0,0,8'hFE,1, 1,8'h05,0,0,0);
    add(1,1,0,0,8'hFE,1, 2,8'h05,0,0,0);
    add(1,0,0,0,8'h00,0, 2,8'h05,0,0,0);
    add(1,0,1,0,8'h00,0, 1,8'hFE,1,0,0);
    add(1,0,0,0,8'h00,0, 1,8'hFE,1,0,0);
    add(1,0,1,0,8'h00,0, 0,8'h00,0,0,0);
    add(1,0,0,0,8'h00,0, 0,8'h00,0,0,0);
    add(1,1,0,0,8'h10,0, 1,8'h10,0,0,0);
    add(1,0,0,0,8'h00,0, 1,8'h10,0,0,0);
    add(1,1,0,0,8'h11,0, 2,8'h10,0,0,0);
    add(1,0,0,0,8'h00,0, 2,8'h10,0,0,0);
    add(1,1,0,0,8'h12,0, 3,8'h10,0,0,0);
    add(1,0,0,0,8'h00,0, 3,8'h10,0,0,0);
    add(1,1,0,0,8'h13,0, 4,8'h10,0,0,0);
    add(1,0,0,0,8'h00,0, 4,8'h10,0,0,0);
    add(1,1,0,0,8'h14,1, 4,8'h10,0,1,0);
    add(1,0,0,0,8'h00,0, 4,8'h10,0,1,0);
    add(1,0,1,0,8'h00,0, 3,8'h11,0,1,0);
    add(1,0,0,0,8'h00,0, 3,8'h11,0,1,0);
    add(1,0,1,0,8'h00,0, 2,8'h12,0,1,0);
    add(1,0,0,0,8'h00,0, 2,8'h12,0,1,0);
    add(1,0,1,0,8'h00,0, 1,8'h13,0,1,0);
    add(1,0,0,0,8'h00,0, 1,8'h13,0,1,0);
    add(1,0,1,0,8'h00,0, 0,8'h00,0,1,0);
    add(1,0,0,0,8'h00,0, 0,8'h00,0,1,0);
    add(1,0,1,0,8'h00,0, 0,8'h00,0,1,1);
    add(1,0,0,0,8'h00,0, 0,8'h00,0,1,1);
    add(1,0,0,1,8'h00,0, 0,8'h00,0,0,0);
    add(0,1,0,0,8'h55,0, 0,8'h00,0,0,0);
    add(0,0,0,0,8'h00,0, 0,8'h00,0,0,0);
    add(0,0,1,0,8'h00,0, 0,8'h00,0,0,0);
    add(0,0,0,0,8'h00,0, 0,8'h00,0,0,0);
    add(0,1,0,0,8'h66,0, 0,8'h00,0,0,0);
    add(1,1,0,0,8'h66,0, 0,8'h00,0,0,0);
    add(1,0,0,0,8'h00,0, 0,8'h00,0,0,0);
    add(1,1,0,0,8'h77,1, 1,8'h77,1,0,0);
    add(1,0,0,0,8'h00,0, 1,8'h77,1,0,0);
    add(0,0,1,0,8'h00,0, 1,8'h77,1,0,0);
    add(0,0,0,1,8'h00,0, 1,8'h77,1,0,0);
    add(1,0,0,0,8'h00,0, 1,8'h77,1,0,0);
    add(1,1,1,1,8'h88,0, 0,8'h00,0,0,0);
    add(1,0,0,0,8'h00,0, 0,8'h00,0,0,0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].ena, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].diff, vecs[i].bor);
      chk_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_dout, vecs[i].e_bor,
                vecs[i].e_ovf, vecs[i].e_udf);
    end

    // Held push strobe: one event only.
    for (int k = 0; k < 10; k++) step(1, 1, 0, 0, 8'h33, 0);
    chk_state("held_push", 1, 8'h33, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk_state("held_drain", 0, 8'h00, 0, 0, 0);

    // Fill, then simultaneous push+pop on a full FIFO.
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 0, 8'hA0 + 8'(k), 0);
      step(1, 0, 0, 0, 8'h00, 0);
    end
    chk_state("fill4", 4, 8'hA0, 0, 0, 0);
    step(1, 1, 1, 0, 8'hAA, 1);
    chk_state("full_pushpop", 4, 8'hA1, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk_state("fp_pop1", 3, 8'hA2, 0, 0, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk_state("fp_pop2", 2, 8'hA3, 0, 0, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk_state("fp_last", 1, 8'hAA, 1, 0, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    chk_state("fp_empty", 0, 8'h00, 0, 0, 0);

    // Simultaneous push+pop while empty: push lands, pop flags underflow.
    step(1, 1, 1, 0, 8'h5C, 1);
    chk_state("empty_pushpop", 1, 8'h5C, 1, 0, 1);
    step(1, 0, 0, 1, 8'h00, 0);
    chk_state("empty_pp_clr", 0, 8'h00, 0, 0, 0);

    // Six push/pop pairs walk the pointers past the wrap point.
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 0, 0, 8'h40 + 8'(k), 1'(k));
      step(1, 0, 0, 0, 8'h00, 0);
      chk_state($sformatf("wrap_push%0d", k), 1, 8'h40 + 8'(k), 1'(k), 0, 0);
      step(1, 0, 1, 0, 8'h00, 0);
      step(1, 0, 0, 0, 8'h00, 0);
      chk_state($sformatf("wrap_pop%0d", k), 0, 8'h00, 0, 0, 0);
    end

    // Async reset mid-cycle with entries present and a flag set.
    step(1, 1, 0, 0, 8'hC1, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 0, 8'hC2, 1);
    chk_state("pre_reset", 1, 8'hC2, 1, 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_reset", 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 8'h00, 0);
    chk_state("post_reset", 0, 8'h00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sub_result_fifo.md
Name: sub_result_fifo

Overview:
- Downstream capture stage for the 8-bit subtractor result (minuend minus subtrahend, modulo 256) and its borrow bit.
- On each rising edge of a push strobe, stores the current difference plus borrow.
- Holds up to DEPTH entries.
- Lets the host read them back one at a time with a pop strobe on slow, pin-driven inputs.

Parameters:
- WIDTH, 8, data width of the difference word.
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; when 0, no push/pop/clear takes effect
- diff_in  input  WIDTH  difference from subtractor stage
- borrow_in  input  1  borrow from subtractor stage (1 when minuend < subtrahend)
- push_req  input  1  level strobe; rising edge requests a push
- pop_req  input  1  level strobe; rising edge requests a pop
- clr  input  1  synchronous clear, active high
- dout  output  WIDTH  head-entry difference
- borrow_out  output  1  head-entry borrow
- empty  output  1  no entries stored
- full  output  1  DEPTH entries stored
- count  output  $clog2(DEPTH)+1  entries stored, 0..DEPTH
- overflow  output  1  sticky: a push was rejected because the FIFO was full
- underflow  output  1  sticky: a pop was rejected because the FIFO was empty

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Pointers, count, overflow, underflow and edge-detect registers clear to 0.
  - Outputs: empty=1, full=0, dout=0, borrow_out=0.
  - Storage contents need not be cleared.
- Edge detect:
  - push_q and pop_q register push_req/pop_req every clk regardless of ena.
  - push_ev = push_req & ~push_q & ena; pop_ev = pop_req & ~pop_q & ena.
  - A held-high strobe produces exactly one event.
  - Strobes are treated as already synchronous; no synchroniser is required inside this block.
- Storage: DEPTH entries of WIDTH+1 bits, holding {borrow, diff}.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push:
  - On push_ev with count<DEPTH: write {borrow_in, diff_in} at wr_ptr, then wr_ptr+1, count+1.
  - Data is sampled in the same clk cycle that push_ev is high.
- Pop: on pop_ev with count>0: rd_ptr+1, count-1.
- Simultaneous push_ev and pop_ev:
  - count>0 (including full): both happen, count unchanged, no overflow flagged. The popped entry is the old head; the pushed entry goes to the tail.
  - count==0: push happens, pop is rejected, underflow sets. After the cycle count=1 and the head is the new entry.
- Rejected operations:
  - push_ev while full: no write, overflow<=1.
  - pop_ev while empty: no pointer change, underflow<=1.
  - overflow and underflow stay set until clr or reset.
- Outputs:
  - dout/borrow_out = storage[rd_ptr] when count>0, else 0. Combinational from registered state, so valid the cycle after a push or pop commits.
  - empty = (count==0); full = (count==DEPTH).
- clr with ena=1:
  - Next edge: pointers, count, overflow and underflow go to 0.
  - Takes priority over any push_ev/pop_ev in the same cycle; those events are dropped and set no flags.
- ena=0: no state change other than the edge registers. A strobe edge that occurs while ena=0 is lost; it is not replayed when ena returns.
- Latency: push to visible head (when the FIFO was empty) is 1 clk after the push_ev cycle.
- Reset asserted mid-operation: all state aborts immediately to reset values; no partial write is retained as valid.

Test Plan:
- Reset then idle → empty=1, count=0, dout=0, borrow_out=0, overflow=0, underflow=0.
- Push diff_in=0x05/borrow=0, then 0xFE/borrow=1 (i.e. 3−5), then pop twice → dout reads 0x05/0, then 0xFE/1, then 0 with empty=1; count goes 1,2,1,0.
- Push 5 entries 0x10..0x14 with DEPTH=4 → full=1 after the 4th push, overflow=1 after the 5th; pops return 0x10..0x13 in order (0x14 never stored).
- Hold push_req high for 10 clks → exactly one entry stored (count=1).
- Full FIFO, push_req and pop_req rise in the same cycle with diff_in=0xAA → count stays 4, overflow=0, head advances to the 2nd entry, 0xAA is the last entry popped.
- Pop while empty → underflow=1, count=0. Then clr → underflow=0. Then push/pop with ena=0 → no change; 6 push/pop cycles exercise pointer wrap and data stays in order.
